// File: rtl/cache_control.sv
// rtl/cache_control.sv - sequencing FSM for the 2-way set-associative cache datapath.
// Optional: `CACHE_PERF_CNT_EN adds hit/miss/writeback counters.
module cache_control #(
  parameter int PMEM_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic        mem_resp,
  input  logic        hit,
  input  logic        dirty,
  input  logic        pmem_resp,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic        pmem_addr_sel,
  output logic        rd_valid,
  output logic        rd_tag,
  output logic        rd_dirty,
  output logic        rd_lru,
  output logic        rd_data,
  output logic        ld_valid,
  output logic        ld_tag,
  output logic        ld_dirty,
  output logic        ld_lru,
  output logic        ld_data,
  output logic        datain_mux_sel,
  output logic        dirty_in,
  output logic        valid_in,
`ifdef CACHE_PERF_CNT_EN
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
  output logic [31:0] wb_count,
`endif
  output logic        err
);

  typedef enum logic [2:0] {IDLE, CHECK, WRITEBACK, FILL, REREAD} state_t;

  localparam logic [31:0] TIMEOUT_M1 = 32'(PMEM_TIMEOUT - 1);

  state_t      state, state_next;
  logic        op_write;
  logic [31:0] to_cnt;
  logic        waiting;

  assign waiting = (state == WRITEBACK) || (state == FILL);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (mem_read || mem_write) state_next = CHECK;
      CHECK:     state_next = hit ? IDLE : (dirty ? WRITEBACK : FILL);
      WRITEBACK: if (pmem_resp) state_next = FILL;
      FILL:      if (pmem_resp) state_next = REREAD;
      REREAD:    state_next = CHECK;
      default:   state_next = IDLE;
    endcase
  end

  // Strobes are Mealy on hit/pmem_resp; forced low while rst is high.
  always_comb begin
    mem_resp = 1'b0; pmem_read = 1'b0; pmem_write = 1'b0; pmem_addr_sel = 1'b0;
    rd_valid = 1'b0; rd_tag = 1'b0; rd_dirty = 1'b0; rd_lru = 1'b0; rd_data = 1'b0;
    ld_valid = 1'b0; ld_tag = 1'b0; ld_dirty = 1'b0; ld_lru = 1'b0; ld_data = 1'b0;
    datain_mux_sel = 1'b0; dirty_in = 1'b0; valid_in = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: if (mem_read || mem_write) begin
          {rd_valid, rd_tag, rd_dirty, rd_lru, rd_data} = 5'b11111;
        end
        CHECK: begin
          {rd_valid, rd_tag, rd_dirty, rd_lru, rd_data} = 5'b11111;
          if (hit) begin
            mem_resp = 1'b1;
            ld_lru   = 1'b1;
            if (op_write) begin
              ld_data        = 1'b1;
              datain_mux_sel = 1'b1;
              ld_dirty       = 1'b1;
              dirty_in       = 1'b1;
            end
          end
        end
        WRITEBACK: begin
          pmem_write    = 1'b1;
          pmem_addr_sel = 1'b1;
          rd_data       = 1'b1;
        end
        FILL: begin
          pmem_read = 1'b1;
          if (pmem_resp) begin
            ld_data  = 1'b1;
            ld_tag   = 1'b1;
            ld_valid = 1'b1;
            valid_in = 1'b1;
            ld_dirty = 1'b1;
          end
        end
        REREAD: {rd_valid, rd_tag, rd_dirty, rd_lru, rd_data} = 5'b11111;
        default: ;
      endcase
    end
  end

  // The operation is latched at request time so a dropped request still completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      op_write <= 1'b0;
      to_cnt   <= '0;
      err      <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE) op_write <= mem_write;
      if (!waiting || state_next != state) to_cnt <= '0;
      else if (to_cnt != '1) to_cnt <= to_cnt + 32'd1;
      if (PMEM_TIMEOUT > 0 && waiting && to_cnt == TIMEOUT_M1) err <= 1'b1;
    end
  end

`ifdef CACHE_PERF_CNT_EN
  logic missed;

  always_ff @(posedge clk) begin
    if (rst) begin
      missed     <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      if (state == IDLE) missed <= 1'b0;
      else if (state == CHECK && !hit) missed <= 1'b1;
      if (state == CHECK && hit && !missed && hit_count != '1) hit_count <= hit_count + 32'd1;
      if (state == CHECK && !hit && miss_count != '1) miss_count <= miss_count + 32'd1;
      if (state == WRITEBACK && pmem_resp && wb_count != '1) wb_count <= wb_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_control.sv
// tb/tb_cache_control.sv - directed self-checking bench for cache_control.
module tb_cache_control;

  logic clk, rst, mem_read, mem_write, hit, dirty, pmem_resp;
  logic mem_resp, pmem_read, pmem_write, pmem_addr_sel;
  logic rd_valid, rd_tag, rd_dirty, rd_lru, rd_data;
  logic ld_valid, ld_tag, ld_dirty, ld_lru, ld_data;
  logic datain_mux_sel, dirty_in, valid_in, err;
`ifdef CACHE_PERF_CNT_EN
  logic [31:0] hit_count, miss_count, wb_count;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [17:0] RESP   = 18'h20000;
  localparam logic [17:0] PRD    = 18'h10000;
  localparam logic [17:0] PWR    = 18'h08000;
  localparam logic [17:0] ASEL   = 18'h04000;
  localparam logic [17:0] RD_ALL = 18'h03E00;
  localparam logic [17:0] RDDATA = 18'h00200;
  localparam logic [17:0] LDVAL  = 18'h00100;
  localparam logic [17:0] LDTAG  = 18'h00080;
  localparam logic [17:0] LDDRT  = 18'h00040;
  localparam logic [17:0] LDLRU  = 18'h00020;
  localparam logic [17:0] LDDAT  = 18'h00010;
  localparam logic [17:0] DMUX   = 18'h00008;
  localparam logic [17:0] DIN    = 18'h00004;
  localparam logic [17:0] VIN    = 18'h00002;
  localparam logic [17:0] ERR    = 18'h00001;

  localparam logic [17:0] READ_HIT  = RD_ALL | RESP | LDLRU;
  localparam logic [17:0] WRITE_HIT = RD_ALL | RESP | LDLRU | LDDAT | DMUX | LDDRT | DIN;
  localparam logic [17:0] FILL_DONE = PRD | LDDAT | LDTAG | LDVAL | VIN | LDDRT;
  localparam logic [17:0] WB        = PWR | ASEL | RDDATA;

  cache_control #(.PMEM_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
    .hit(hit), .dirty(dirty), .pmem_resp(pmem_resp), .pmem_read(pmem_read),
    .pmem_write(pmem_write), .pmem_addr_sel(pmem_addr_sel),
    .rd_valid(rd_valid), .rd_tag(rd_tag), .rd_dirty(rd_dirty), .rd_lru(rd_lru), .rd_data(rd_data),
    .ld_valid(ld_valid), .ld_tag(ld_tag), .ld_dirty(ld_dirty), .ld_lru(ld_lru), .ld_data(ld_data),
    .datain_mux_sel(datain_mux_sel), .dirty_in(dirty_in), .valid_in(valid_in),
`ifdef CACHE_PERF_CNT_EN
    .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count),
`endif
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [17:0] obs();
    return {mem_resp, pmem_read, pmem_write, pmem_addr_sel,
            rd_valid, rd_tag, rd_dirty, rd_lru, rd_data,
            ld_valid, ld_tag, ld_dirty, ld_lru, ld_data,
            datain_mux_sel, dirty_in, valid_in, err};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the outputs in the current cycle, then advance one clock.
  task automatic expect_cyc(input string tag, input logic [17:0] exp);
    #1;
    check(tag, 32'(obs()), 32'(exp));
    tick();
  endtask

  initial begin
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; hit = 1'b0; dirty = 1'b0; pmem_resp = 1'b0;
    tick(); tick();
    expect_cyc("reset_outputs", '0);
    rst = 1'b0;
    expect_cyc("idle_after_reset", '0);

    // Read hit: request in cycle 1, response in cycle 2.
    mem_read = 1'b1; hit = 1'b1;
    expect_cyc("rhit_c1", RD_ALL);
    expect_cyc("rhit_c2", READ_HIT);
    mem_read = 1'b0; hit = 1'b0;
    expect_cyc("rhit_idle", '0);

    // Clean read miss with a 5-cycle fill; response in cycle 9.
    mem_read = 1'b1;
    expect_cyc("cmiss_c1", RD_ALL);
    expect_cyc("cmiss_c2_check", RD_ALL);
    for (int i = 1; i <= 5; i++) begin
      pmem_resp = (i == 5);
      expect_cyc($sformatf("cmiss_fill%0d", i), (i == 5) ? FILL_DONE : PRD);
    end
    pmem_resp = 1'b0;
    expect_cyc("cmiss_c8_reread", RD_ALL);
    hit = 1'b1;
    expect_cyc("cmiss_c9_resp", READ_HIT);
    mem_read = 1'b0; hit = 1'b0;
    expect_cyc("cmiss_idle", '0);

    // Dirty write miss: 3-cycle writeback, 2-cycle fill, then write merge on re-check.
    mem_write = 1'b1; dirty = 1'b1;
    expect_cyc("dmiss_c1", RD_ALL);
    expect_cyc("dmiss_check", RD_ALL);
    dirty = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      pmem_resp = (i == 3);
      expect_cyc($sformatf("dmiss_wb%0d", i), WB);
    end
    pmem_resp = 1'b0;
    expect_cyc("dmiss_fill1", PRD);
    pmem_resp = 1'b1;
    expect_cyc("dmiss_fill2", FILL_DONE);
    pmem_resp = 1'b0;
    expect_cyc("dmiss_reread", RD_ALL);
    hit = 1'b1;
    expect_cyc("dmiss_merge", WRITE_HIT);
    mem_write = 1'b0; hit = 1'b0;
    expect_cyc("dmiss_idle", '0);

    // Write hit.
    mem_write = 1'b1; hit = 1'b1;
    expect_cyc("whit_c1", RD_ALL);
    expect_cyc("whit_c2", WRITE_HIT);
    mem_write = 1'b0;
    expect_cyc("whit_idle", '0);

    // Both request lines high behaves as a write.
    mem_read = 1'b1; mem_write = 1'b1;
    expect_cyc("both_c1", RD_ALL);
    expect_cyc("both_c2", WRITE_HIT);
    mem_read = 1'b0; mem_write = 1'b0; hit = 1'b0;

    // pmem_resp in IDLE is ignored.
    pmem_resp = 1'b1;
    expect_cyc("stray_idle1", '0);
    pmem_resp = 1'b0;
    expect_cyc("stray_idle2", '0);

    // Reset in the middle of a fill.
    mem_read = 1'b1;
    expect_cyc("rfill_c1", RD_ALL);
    expect_cyc("rfill_check", RD_ALL);
    expect_cyc("rfill_fill", PRD);
    rst = 1'b1; mem_read = 1'b0;
    expect_cyc("rfill_in_reset", '0);
    rst = 1'b0; pmem_resp = 1'b1;
    expect_cyc("rfill_after_stray", '0);
    pmem_resp = 1'b0;
    expect_cyc("rfill_idle", '0);

    // Timeout: err rises after 8 fill cycles, fill request held.
    mem_read = 1'b1;
    expect_cyc("to_c1", RD_ALL);
    expect_cyc("to_check", RD_ALL);
    for (int i = 1; i <= 8; i++) expect_cyc($sformatf("to_fill%0d", i), PRD);
    expect_cyc("to_err_set", PRD | ERR);
    pmem_resp = 1'b1;
    expect_cyc("to_late_resp", FILL_DONE | ERR);
    pmem_resp = 1'b0;
    expect_cyc("to_reread", RD_ALL | ERR);
    hit = 1'b1;
    expect_cyc("to_resp", READ_HIT | ERR);
    mem_read = 1'b0; hit = 1'b0;
    expect_cyc("to_err_sticky", ERR);
`ifdef CACHE_PERF_CNT_EN
    check("perf_hit", hit_count, 32'd0);
    check("perf_miss", miss_count, 32'd1);
    check("perf_wb", wb_count, 32'd0);
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_cyc("to_err_cleared", '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
